mux_large_stream: RTL and testbench

//   Parametrised N-channel, WIDTH-bit streaming multiplexer with a valid/ready

---
 rtl/mux_stream_pkg.sv | 18 +
 rtl/mux_large_stream_rr_arbiter.sv | 34 +++
 rtl/mux_large_stream.sv | 120 ++++++++++++
 tb/tb_mux_large_stream.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mux_stream_pkg.sv
// Shared definitions for the streaming channel multiplexer: mode encodings
// and the select-width helper.
package mux_stream_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Ceil(log2(n)) with a floor of 1, so a 2-channel mux still has a 1-bit select.
  function automatic int clog2_min1(input int n);
    int r;
    r = 32'sd1;
    for (int i = 1; i < 31; i++) begin
      r = ((32'sd1 << i) < n) ? i + 32'sd1 : r;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_large_stream_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or above ptr wins,
// wrapping modulo NUM_CH.
module rr_arbiter
  import mux_stream_pkg::*;
#(
  parameter int NUM_CH = 10,
  parameter int SEL_W  = clog2_min1(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx
);
  localparam int DW = 2 * NUM_CH;
  localparam logic [DW-1:0]     ONE_DW = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [NUM_CH-1:0] ONE_N  = {{(NUM_CH-1){1'b0}}, 1'b1};

  logic [DW-1:0] req_dbl_s;
  int            idx_s;
  int            ch_s;

  // Upper copy of req covers the wrap-around; bits below ptr in the lower copy are masked.
  always_comb begin
    req_dbl_s = {req, req} & ~((ONE_DW << ptr) - ONE_DW);
    idx_s     = 32'sd0;
    for (int j = DW - 1; j >= 0; j--) begin
      idx_s = req_dbl_s[j] ? j : idx_s;
    end
    ch_s      = (idx_s >= NUM_CH) ? idx_s - NUM_CH : idx_s;
    grant     = (|req) ? (ONE_N << ch_s) : {NUM_CH{1'b0}};
    grant_idx = (|req) ? SEL_W'(ch_s) : {SEL_W{1'b0}};
  end

endmodule

// File: rtl/mux_large_stream.sv
// N-channel streaming multiplexer with valid/ready handshakes, external-select
// or round-robin channel choice, and a single registered output stage.
module mux_large_stream
  import mux_stream_pkg::*;
#(
  parameter int NUM_CH = 10,
  parameter int WIDTH  = 8,
  parameter int SEL_W  = clog2_min1(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    clr_err,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);
  localparam logic [NUM_CH-1:0] ONE_N    = {{(NUM_CH-1){1'b0}}, 1'b1};
  localparam logic [SEL_W-1:0]  LAST_CH  = SEL_W'(NUM_CH - 1);
  localparam logic [SEL_W:0]    NUM_CH_W = (SEL_W + 1)'(NUM_CH);

  logic [NUM_CH-1:0] rr_grant_s;
  logic [SEL_W-1:0]  rr_idx_s;
  logic [NUM_CH-1:0] grant_s;
  logic [SEL_W-1:0]  grant_idx_s;
  logic              sel_bad_s;
  logic              can_accept_s;
  logic              xfer_s;

  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;
  logic              out_valid_q, out_valid_d;
  logic              sel_err_q, sel_err_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;

  rr_arbiter #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) u_arb (
    .req       (in_valid),
    .ptr       (rr_ptr_q),
    .grant     (rr_grant_s),
    .grant_idx (rr_idx_s)
  );

  // Channel grant: round-robin winner, or the selected channel when in range.
  always_comb begin
    grant_s     = {NUM_CH{1'b0}};
    grant_idx_s = {SEL_W{1'b0}};
    sel_bad_s   = 1'b0;
    if (mode == MODE_RR) begin
      grant_s     = rr_grant_s;
      grant_idx_s = rr_idx_s;
    end else if ({1'b0, sel} < NUM_CH_W) begin
      grant_s     = in_valid & (ONE_N << sel);
      grant_idx_s = sel;
    end else begin
      sel_bad_s   = 1'b1;
    end
  end

  assign can_accept_s = ~out_valid_q | out_ready;
  assign in_ready     = grant_s & {NUM_CH{can_accept_s}};
  assign xfer_s       = |(in_valid & in_ready);

  // Next state of the output stage, round-robin pointer and sticky select error.
  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer_s) begin
      out_data_d  = in_data[int'(grant_idx_s) * WIDTH +: WIDTH];
      out_ch_d    = grant_idx_s;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (xfer_s && (mode == MODE_RR)) begin
      rr_ptr_d = (grant_idx_s == LAST_CH) ? {SEL_W{1'b0}} : grant_idx_s + {{(SEL_W-1){1'b0}}, 1'b1};
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    if (sel_bad_s) begin
      sel_err_d = 1'b1;
    end else if (clr_err) begin
      sel_err_d = 1'b0;
    end else begin
      sel_err_d = sel_err_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= {WIDTH{1'b0}};
      out_ch_q    <= {SEL_W{1'b0}};
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
      rr_ptr_q    <= {SEL_W{1'b0}};
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_large_stream.sv
// Self-checking bench for mux_large_stream: directed stimulus, a cycle model
// checked on every falling edge, and literal expectations for key sequences.
module tb_mux_large_stream;
  import mux_stream_pkg::*;

  localparam int NUM_CH = 10;
  localparam int WIDTH  = 8;
  localparam int SEL_W  = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic                    clr_err;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;

  logic [WIDTH-1:0] dat [NUM_CH];
  int n_cmp = 0;
  int n_bad = 0;
  int seen [$];

  logic [WIDTH-1:0] m_data  = 8'h00;
  int               m_ch    = 0;
  logic             m_valid = 1'b0;
  logic             m_err   = 1'b0;
  int               m_ptr   = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) in_data[i*WIDTH +: WIDTH] = dat[i];
  end

  mux_large_stream dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .clr_err(clr_err),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready), .sel_err(sel_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: expected registered outputs, advanced once per cycle from the rules.
  initial begin : compare
    int win, c, s;
    logic can;
    logic [NUM_CH-1:0] exp_ready;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_valid = 1'b0; m_data = 8'h00; m_ch = 0; m_err = 1'b0; m_ptr = 0;
      end else begin
        chk("m_out_valid", 32'(out_valid), 32'(m_valid));
        chk("m_out_data", 32'(out_data), 32'(m_data));
        chk("m_out_ch", 32'(out_ch), 32'(m_ch));
        chk("m_sel_err", 32'(sel_err), 32'(m_err));
        if (out_valid && out_ready) seen.push_back(int'(out_ch));
        win = -1;
        can = !m_valid || out_ready;
        s = int'(sel);
        if (mode == MODE_SEL) begin
          if (s < NUM_CH && in_valid[s]) win = s;
        end else begin
          for (int k = 0; k < NUM_CH; k++) begin
            c = (m_ptr + k) % NUM_CH;
            if (win < 0 && in_valid[c]) win = c;
          end
        end
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = can;
        chk("m_in_ready", 32'(in_ready), 32'(exp_ready));
        if (mode == MODE_SEL && s >= NUM_CH) m_err = 1'b1;
        else if (clr_err) m_err = 1'b0;
        if (win >= 0 && can) begin
          m_data = dat[win]; m_ch = win; m_valid = 1'b1;
          if (mode == MODE_RR) m_ptr = (win + 1) % NUM_CH;
        end else if (out_ready) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  initial begin : stim
    int exp3 [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
    int exp4 [5]  = '{4, 7, 2, 7, 2};
    int exp6 [3]  = '{0, 1, 2};
    rst_n = 1'b0; in_valid = '0; mode = MODE_SEL; sel = 4'd0; clr_err = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) dat[i] = 8'(i * 17);
    dat[3] = 8'hA5;
    #3;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_ch", 32'(out_ch), 32'd0);
    chk("rst_err", 32'(sel_err), 32'd0);
    #4 rst_n = 1'b1;
    step();

    // 1: SEL mode, channel 3
    sel = 4'd3; in_valid = 10'h008;
    #2 chk("t1_ready", 32'(in_ready), 32'h008);
    step();
    chk("t1_data", 32'(out_data), 32'hA5);
    chk("t1_ch", 32'(out_ch), 32'd3);
    chk("t1_valid", 32'(out_valid), 32'd1);

    // 2: out-of-range select, then clear (set wins over clear)
    sel = 4'd12; in_valid = 10'h3FF;
    #2 chk("t2_ready", 32'(in_ready), 32'h000);
    step();
    chk("t2_err", 32'(sel_err), 32'd1);
    chk("t2_valid", 32'(out_valid), 32'd0);
    clr_err = 1'b1;
    step();
    chk("t2_err_prio", 32'(sel_err), 32'd1);
    sel = 4'd0; in_valid = '0;
    step();
    chk("t2_err_clr", 32'(sel_err), 32'd0);
    clr_err = 1'b0;

    // 3: round-robin over all channels, no bubbles
    mode = MODE_RR; in_valid = 10'h3FF; seen.delete();
    repeat (12) step();
    in_valid = '0;
    #5;
    chk("t3_len", 32'(seen.size()), 32'd12);
    for (int i = 0; i < 12 && i < seen.size(); i++) chk("t3_seq", 32'(seen[i]), 32'(exp3[i]));

    // 4: pointer moved to 5 via ch4, then only ch2/ch7 requesting
    step();
    in_valid = 10'h010; seen.delete();
    step();
    in_valid = 10'h084;
    repeat (4) step();
    in_valid = '0;
    #5;
    chk("t4_len", 32'(seen.size()), 32'd5);
    for (int i = 0; i < 5 && i < seen.size(); i++) chk("t4_seq", 32'(seen[i]), 32'(exp4[i]));

    // 5: backpressure holds data and blocks inputs, then drain+refill
    step(); step();
    in_valid = 10'h3FF; out_ready = 1'b0;
    step();
    chk("t5_first_ch", 32'(out_ch), 32'd3);
    for (int i = 0; i < 3; i++) begin
      #1 chk("t5_stall_ready", 32'(in_ready), 32'h000);
      step();
      chk("t5_stall_data", 32'(out_data), 32'hA5);
      chk("t5_stall_ch", 32'(out_ch), 32'd3);
    end
    out_ready = 1'b1;
    #1 chk("t5_refill_ready", 32'(in_ready), 32'h010);
    step();
    chk("t5_refill_ch", 32'(out_ch), 32'd4);
    chk("t5_refill_data", 32'(out_data), 32'h44);
    chk("t5_refill_valid", 32'(out_valid), 32'd1);

    // 6: asynchronous reset mid-stream, RR restarts at channel 0
    step(); step();
    #2 rst_n = 1'b0;
    #1 chk("t6_async_valid", 32'(out_valid), 32'd0);
    chk("t6_async_ch", 32'(out_ch), 32'd0);
    step();
    #1 rst_n = 1'b1; seen.delete();
    repeat (3) step();
    in_valid = '0;
    #5;
    chk("t6_len", 32'(seen.size()), 32'd3);
    for (int i = 0; i < 3 && i < seen.size(); i++) chk("t6_seq", 32'(seen[i]), 32'(exp6[i]));

    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
